// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: PC, imem req/ack reads, valid/ready instruction output.
// Optional MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault and halts fetching.
module instr_fetch #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
`ifdef MISALIGN_TRAP_EN
        ,
        S_FAULT
`endif
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target_pc;

    assign target_pc = redirect_pc & ALIGN_MASK;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fetch_fault <= 1'b0;
`endif
        end else
`ifdef MISALIGN_TRAP_EN
        // A request already on the bus must complete; afterwards fetching stops for good.
        if (state == S_FAULT || misaligned) begin
            state       <= S_FAULT;
            fetch_fault <= 1'b1;
            instr_valid <= 1'b0;
            if (imem_ack)
                imem_req <= 1'b0;
        end else
`endif
        begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= target_pc;
                        imem_addr <= target_pc;
                    end else begin
                        imem_addr <= pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        pc <= target_pc;
                        // Ack data belongs to the stale stream; reissue at the target straight away.
                        if (imem_ack)
                            imem_addr <= target_pc;
                        else
                            state <= S_DROP;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        pc          <= pc + XLEN'(4);
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc          <= target_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= target_pc;
                        state       <= S_REQ;
                    end else if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redirect)
                        pc <= target_pc;
                    if (imem_ack) begin
                        imem_addr <= redirect ? target_pc : pc;
                        state     <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
